// File: rtl/phase_shift_loader.sv
`default_nettype none
// ============================================================================
//  Module   : phase_shift_loader
//  Purpose  : Buffers one frame of phase words from the lookup stage, shifts it
//             serially (last element first, MSB first) into the T/R phase
//             shifter chain and strobes a common latch enable.
//  Revision : 1.0  initial release
// ============================================================================
module phase_shift_loader #(
    parameter int N_ELEM = 16,
    parameter int PW     = 5,
    parameter int DIV    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          ph_valid,
    input  logic [PW-1:0] ph_in,
    output logic          ph_ready,
    output logic          sclk,
    output logic          sdata,
    output logic          sle,
    output logic          busy,
    output logic          done
);

    localparam int c_idx_w  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int c_elem_w = $clog2(N_ELEM + 1);
    localparam int c_bit_w  = (PW > 1) ? $clog2(PW) : 1;
    localparam int c_div_w  = $clog2(DIV) + 1;

    localparam logic [c_elem_w-1:0] c_elem_last   = c_elem_w'(N_ELEM - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last    = c_bit_w'(PW - 1);
    localparam logic [c_div_w-1:0]  c_div_bit_end = c_div_w'(2 * DIV - 1);
    localparam logic [c_div_w-1:0]  c_div_lo_end  = c_div_w'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_SHIFT = 3'd2,
        S_LATCH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_q,    state_d;
    logic [c_elem_w-1:0]   elem_cnt_q, elem_cnt_d;
    logic [c_bit_w-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [c_div_w-1:0]    div_cnt_q,  div_cnt_d;
    logic                  ph_ready_q, ph_ready_d;
    logic                  sclk_q,     sclk_d;
    logic                  sdata_q,    sdata_d;
    logic                  sle_q,      sle_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;
    logic [PW-1:0]         buf_q [N_ELEM];
    logic [PW-1:0]         buf_d [N_ELEM];

    logic [c_idx_w-1:0]    w_wr_idx;
    logic                  w_word_end;
    logic [c_elem_w-1:0]   w_nxt_elem;
    logic [c_bit_w-1:0]    w_nxt_bit;
    logic [PW-1:0]         w_rd_word;
    logic                  w_rd_bit;

    assign w_wr_idx   = elem_cnt_q[c_idx_w-1:0];

    // Bit that will be on sdata once the current bit period ends; derived only
    // from registered counters so the next-state logic stays loop-free.
    assign w_word_end = (bit_cnt_q == c_bit_last);
    assign w_nxt_elem = w_word_end ? (elem_cnt_q - 1'b1) : elem_cnt_q;
    assign w_nxt_bit  = w_word_end ? '0 : (bit_cnt_q + 1'b1);
    assign w_rd_word  = buf_q[w_nxt_elem[c_idx_w-1:0]];
    assign w_rd_bit   = w_rd_word[c_bit_last - w_nxt_bit];

    always_comb begin
        state_d    = state_q;
        elem_cnt_d = elem_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        ph_ready_d = 1'b0;
        sclk_d     = 1'b0;
        sdata_d    = 1'b0;
        sle_d      = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        buf_d      = buf_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (en) begin
                    state_d    = S_FILL;
                    busy_d     = 1'b1;
                    ph_ready_d = 1'b1;
                    elem_cnt_d = '0;
                end
            end

            S_FILL: begin
                busy_d     = 1'b1;
                ph_ready_d = 1'b1;
                if (ph_valid && ph_ready_q) begin
                    buf_d[w_wr_idx] = ph_in;
                    if (elem_cnt_q == c_elem_last) begin
                        // The word arriving now is the first one shifted out.
                        state_d    = S_SHIFT;
                        ph_ready_d = 1'b0;
                        bit_cnt_d  = '0;
                        div_cnt_d  = '0;
                        sdata_d    = ph_in[PW-1];
                    end else begin
                        elem_cnt_d = elem_cnt_q + 1'b1;
                    end
                end
            end

            S_SHIFT: begin
                busy_d = 1'b1;
                if (div_cnt_q == c_div_bit_end) begin
                    div_cnt_d = '0;
                    bit_cnt_d = w_nxt_bit;
                    if (w_word_end && (elem_cnt_q == '0)) begin
                        state_d = S_LATCH;
                        sle_d   = 1'b1;
                    end else begin
                        elem_cnt_d = w_nxt_elem;
                        sdata_d    = w_rd_bit;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                    sclk_d    = (div_cnt_q >= c_div_lo_end);
                    sdata_d   = sdata_q;
                end
            end

            S_LATCH: begin
                busy_d = 1'b1;
                sle_d  = 1'b1;
                if (div_cnt_q == c_div_lo_end) begin
                    state_d   = S_DONE;
                    sle_d     = 1'b0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            elem_cnt_q <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            ph_ready_q <= 1'b0;
            sclk_q     <= 1'b0;
            sdata_q    <= 1'b0;
            sle_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            elem_cnt_q <= elem_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            ph_ready_q <= ph_ready_d;
            sclk_q     <= sclk_d;
            sdata_q    <= sdata_d;
            sle_q      <= sle_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Frame storage carries no reset; sdata only ever reads it during SHIFT.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign ph_ready = ph_ready_q;
    assign sclk     = sclk_q;
    assign sdata    = sdata_q;
    assign sle      = sle_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_shift_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phase_shift_loader
//  Purpose  : Self-checking bench for phase_shift_loader (default and small
//             configurations) against a frame-level bit-stream model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_phase_shift_loader;

    localparam int N   = 16;
    localparam int PW  = 5;
    localparam int DIV = 4;
    localparam int S   = N * PW * 2 * DIV;

    localparam int SN   = 2;
    localparam int SDIV = 1;
    localparam int SS   = SN * PW * 2 * SDIV;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0, ph_valid = 1'b0;
    logic [PW-1:0] ph_in = '0;
    logic          ph_ready, sclk, sdata, sle, busy, done;

    logic          s_en = 1'b0, s_ph_valid = 1'b0;
    logic [PW-1:0] s_ph_in = '0;
    logic          s_ph_ready, s_sclk, s_sdata, s_sle, s_busy, s_done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [PW-1:0] frame_w [N];

    always #5 clk = ~clk;

    phase_shift_loader #(.N_ELEM(N), .PW(PW), .DIV(DIV)) u_dut (
        .clk(clk), .rst(rst), .en(en), .ph_valid(ph_valid), .ph_in(ph_in),
        .ph_ready(ph_ready), .sclk(sclk), .sdata(sdata), .sle(sle),
        .busy(busy), .done(done)
    );

    phase_shift_loader #(.N_ELEM(SN), .PW(PW), .DIV(SDIV)) u_small (
        .clk(clk), .rst(rst), .en(s_en), .ph_valid(s_ph_valid), .ph_in(s_ph_in),
        .ph_ready(s_ph_ready), .sclk(s_sclk), .sdata(s_sdata), .sle(s_sle),
        .busy(s_busy), .done(s_done)
    );

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; ph_valid = 1'b1; ph_in = PW'($urandom);
        s_en = 1'b1; s_ph_valid = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ph_ready, sclk, sdata, sle, busy, done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: actual=%b expected=000000",
                     {ph_ready, sclk, sdata, sle, busy, done});
        end
        n_cmp++;
        if ({s_ph_ready, s_sclk, s_sdata, s_sle, s_busy, s_done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs_small: actual=%b expected=000000",
                     {s_ph_ready, s_sclk, s_sdata, s_sle, s_busy, s_done});
        end
        rst = 1'b0; en = 1'b0; ph_valid = 1'b1; s_en = 1'b0; s_ph_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ph_ready, busy, done} !== 3'b0) begin
            n_fail++;
            $display("FAIL idle_ignores_valid: actual=%b expected=000", {ph_ready, busy, done});
        end
        ph_valid = 1'b0;
    endtask

    task automatic test_basic_small();
        logic [9:0] exp_stream;
        logic [5:0] act, exp6;
        int         n, first_bad;
        logic [5:0] bad_act, bad_exp;
        exp_stream = 10'b01010_10011;
        first_bad = -1; bad_act = '0; bad_exp = '0;
        s_en = 1'b1; @(negedge clk); n = 1; s_en = 1'b0;
        s_ph_valid = 1'b1; s_ph_in = 5'h13; @(negedge clk); n++;
        s_ph_in = 5'h0A; @(negedge clk); n++;
        s_ph_valid = 1'b0;
        for (int k = 0; k < SS; k++) begin
            if (k > 0) begin @(negedge clk); n++; end
            act  = {s_sclk, s_sdata, s_sle, s_busy, s_ph_ready, s_done};
            exp6 = {((k % (2*SDIV)) >= SDIV) ? 1'b1 : 1'b0, exp_stream[9 - k/(2*SDIV)], 4'b0100};
            if (act !== exp6 && first_bad < 0) begin first_bad = k; bad_act = act; bad_exp = exp6; end
        end
        n_cmp++;
        if (first_bad != -1) begin
            n_fail++;
            $display("FAIL small_shift_stream: cycle %0d actual=%b expected=%b", first_bad, bad_act, bad_exp);
        end
        @(negedge clk); n++;
        n_cmp++;
        if ({s_sclk, s_sdata, s_sle, s_busy, s_ph_ready, s_done} !== 6'b001100) begin
            n_fail++;
            $display("FAIL small_latch: actual=%b expected=001100",
                     {s_sclk, s_sdata, s_sle, s_busy, s_ph_ready, s_done});
        end
        @(negedge clk); n++;
        n_cmp++;
        if ({s_sle, s_busy, s_done} !== 3'b001) begin
            n_fail++;
            $display("FAIL small_done: actual=%b expected=001", {s_sle, s_busy, s_done});
        end
        n_cmp++;
        if (n + 1 !== 1 + SN + SS + SDIV + 1) begin
            n_fail++;
            $display("FAIL small_frame_len: actual=%0d expected=%0d", n + 1, 1 + SN + SS + SDIV + 1);
        end
        @(negedge clk);
        n_cmp++;
        if ({s_busy, s_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL small_after_done: actual=%b expected=00", {s_busy, s_done});
        end
    endtask

    task automatic run_frame(input string tag, input int max_gap, input bit noisy);
        logic       exp_bits [N*PW];
        logic [5:0] act, exp6, bad_act, bad_exp;
        int         n, gaps, gap, idx, ready_bad, first_bad;
        idx = 0;
        for (int e = N - 1; e >= 0; e--)
            for (int b = PW - 1; b >= 0; b--) begin
                exp_bits[idx] = frame_w[e][b];
                idx++;
            end
        n = 0; gaps = 0; ready_bad = 0;
        en = 1'b1; @(negedge clk); n++;
        en = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        n_cmp++;
        if ({busy, ph_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL %s_start: busy,ph_ready actual=%b expected=11", tag, {busy, ph_ready});
        end
        for (int i = 0; i < N; i++) begin
            gap = $urandom_range(0, max_gap);
            ph_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                ph_in = PW'($urandom);
                @(negedge clk); n++; gaps++;
                if (ph_ready !== 1'b1) ready_bad++;
                if (noisy) en = 1'($urandom_range(0, 1));
            end
            ph_valid = 1'b1; ph_in = frame_w[i];
            @(negedge clk); n++;
            if (i < N - 1 && ph_ready !== 1'b1) ready_bad++;
            if (noisy) en = 1'($urandom_range(0, 1));
        end
        ph_valid = 1'b0;
        n_cmp++;
        if (ready_bad !== 0) begin
            n_fail++;
            $display("FAIL %s_fill_ready: low cycles actual=%0d expected=0", tag, ready_bad);
        end
        first_bad = -1; bad_act = '0; bad_exp = '0;
        for (int k = 0; k < S; k++) begin
            if (k > 0) begin @(negedge clk); n++; end
            act  = {sclk, sdata, sle, busy, ph_ready, done};
            exp6 = {((k % (2*DIV)) >= DIV) ? 1'b1 : 1'b0, exp_bits[k/(2*DIV)], 4'b0100};
            if (act !== exp6 && first_bad < 0) begin first_bad = k; bad_act = act; bad_exp = exp6; end
            if (noisy) begin
                en = 1'($urandom_range(0, 1));
                ph_valid = 1'($urandom_range(0, 1));
                ph_in = PW'($urandom);
            end
        end
        ph_valid = 1'b0;
        n_cmp++;
        if (first_bad != -1) begin
            n_fail++;
            $display("FAIL %s_shift_stream: cycle %0d actual=%b expected=%b", tag, first_bad, bad_act, bad_exp);
        end
        first_bad = -1;
        for (int j = 0; j < DIV; j++) begin
            @(negedge clk); n++;
            act = {sclk, sdata, sle, busy, ph_ready, done};
            if (act !== 6'b001100 && first_bad < 0) begin first_bad = j; bad_act = act; end
            if (noisy) en = 1'($urandom_range(0, 1));
        end
        n_cmp++;
        if (first_bad != -1) begin
            n_fail++;
            $display("FAIL %s_latch: cycle %0d actual=%b expected=001100", tag, first_bad, bad_act);
        end
        @(negedge clk); n++;
        n_cmp++;
        if ({sclk, sdata, sle, busy, ph_ready, done} !== 6'b000001) begin
            n_fail++;
            $display("FAIL %s_done_pulse: actual=%b expected=000001", tag,
                     {sclk, sdata, sle, busy, ph_ready, done});
        end
        n_cmp++;
        if (n + 1 !== 1 + N + gaps + S + DIV + 1) begin
            n_fail++;
            $display("FAIL %s_frame_len: actual=%0d expected=%0d", tag, n + 1, 1 + N + gaps + S + DIV + 1);
        end
        en = noisy;
        first_bad = -1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            en = 1'b0;
            act = {sclk, sdata, sle, busy, ph_ready, done};
            if (act !== 6'b0 && first_bad < 0) begin first_bad = j; bad_act = act; end
        end
        n_cmp++;
        if (first_bad != -1) begin
            n_fail++;
            $display("FAIL %s_after_done: cycle %0d actual=%b expected=000000", tag, first_bad, bad_act);
        end
    endtask

    task automatic test_stalled_fill();
        for (int i = 0; i < N; i++) frame_w[i] = PW'($urandom);
        run_frame("stalled", 7, 1'b0);
    endtask

    task automatic test_ignored_requests();
        for (int i = 0; i < N; i++) frame_w[i] = PW'($urandom);
        run_frame("ignored", 3, 1'b1);
    endtask

    task automatic test_boundary_words();
        for (int i = 0; i < N; i++) frame_w[i] = 5'h1F;
        run_frame("ones", 0, 1'b0);
        for (int i = 0; i < N; i++) frame_w[i] = 5'h00;
        run_frame("zeros", 0, 1'b0);
    endtask

    task automatic test_reset_mid_shift();
        int quiet_bad;
        en = 1'b1; @(negedge clk); en = 1'b0;
        for (int i = 0; i < N; i++) begin
            ph_valid = 1'b1; ph_in = PW'($urandom);
            @(negedge clk);
        end
        ph_valid = 1'b0;
        repeat (38 * 2 * DIV) @(negedge clk);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        n_cmp++;
        if ({ph_ready, sclk, sdata, sle, busy, done} !== 6'b0) begin
            n_fail++;
            $display("FAIL mid_shift_reset: actual=%b expected=000000",
                     {ph_ready, sclk, sdata, sle, busy, done});
        end
        quiet_bad = 0;
        for (int k = 0; k < S + 40; k++) begin
            @(negedge clk);
            if ({sclk, sle, busy, done} !== 4'b0) quiet_bad++;
        end
        n_cmp++;
        if (quiet_bad !== 0) begin
            n_fail++;
            $display("FAIL post_reset_quiet: active cycles actual=%0d expected=0", quiet_bad);
        end
        for (int i = 0; i < N; i++) frame_w[i] = PW'($urandom);
        run_frame("after_reset", 0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_small();
        test_stalled_fill();
        test_ignored_requests();
        test_boundary_words();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
